// File: rtl/cphy_pkg.sv
// Shared C-PHY symbol definitions: symbol codes, transmit phases, sync word and
// the symbol-to-wire-state transition used by both the lane encoder and decoder model.
package cphy_pkg;

    localparam logic [2:0] SYM_CCW_SAME = 3'b000;
    localparam logic [2:0] SYM_CCW_OPP  = 3'b001;
    localparam logic [2:0] SYM_CW_SAME  = 3'b010;
    localparam logic [2:0] SYM_CW_OPP   = 3'b011;
    localparam logic [2:0] SYM_OPP_POL  = 3'b100;

    localparam logic [2:0] SYM_PREAMBLE = SYM_CW_OPP;

    typedef enum logic [1:0] {
        PH_IDLE     = 2'd0,
        PH_PREAMBLE = 2'd1,
        PH_SYNC     = 2'd2,
        PH_DATA     = 2'd3
    } phase_e;

    localparam int unsigned SYNC_LEN = 7;
    localparam logic [2:0] SYNC_SEQ [SYNC_LEN] = '{
        SYM_CW_OPP, SYM_OPP_POL, SYM_OPP_POL, SYM_OPP_POL,
        SYM_OPP_POL, SYM_OPP_POL, SYM_CW_OPP
    };

    function automatic logic sym_legal(input logic [2:0] sym);
        return sym <= SYM_OPP_POL;
    endfunction

    // Illegal codes fall through to the CCW-same rotation so a transition still happens.
    function automatic logic [2:0] next_state(input logic [2:0] ps, input logic [2:0] sym);
        logic [2:0] ns;
        case (sym)
            SYM_CCW_OPP:  ns = ~{ps[1:0], ps[2]};
            SYM_CW_SAME:  ns = {ps[0], ps[2:1]};
            SYM_CW_OPP:   ns = ~{ps[0], ps[2:1]};
            SYM_OPP_POL:  ns = ~ps;
            default:      ns = {ps[1:0], ps[2]};
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/cphy_sym_fifo.sv
// Symbol FIFO with wrap-bit pointers; read data is the registered head, no bypass.
// Pushes while full and pops while empty are ignored.
module cphy_sym_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o  = (wr_q == rd_q);
    assign full_o   = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push  = push_i && !full_o;
    assign do_pop   = pop_i && !empty_o;
    assign rd_dat_o = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + PTR_ONE;
        if (do_pop)  rd_d = rd_q + PTR_ONE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wr_dat_i;
    end

endmodule

// File: rtl/cphy_symbol_encoder.sv
// C-PHY master lane encoder: preamble, sync word, then FIFO data; State is one cycle after each pop.
// SymReady drops only when the symbol FIFO is full; empty FIFO in DATA sends a filler.
module cphy_symbol_encoder
    import cphy_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter logic [2:0]  RESET_STATE  = 3'b011
) (
    input  logic       TxSymbolClkHS,
    input  logic       reset,
    input  logic       EncoderEn,
    input  logic [2:0] SymIn,
    input  logic       SymValid,
    output logic       SymReady,
    output logic [2:0] State,
    output logic [1:0] Phase,
    output logic       Underflow,
    output logic       SymErr
);

    localparam int unsigned CNT_MAX = (PREAMBLE_LEN > SYNC_LEN) ? PREAMBLE_LEN : SYNC_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] SYN_LAST = CNT_W'(SYNC_LEN - 1);

    phase_e           phase_q, phase_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             undf_q, undf_d;
    logic             err_q, err_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic [2:0]       fifo_head;
    logic             pop;
    logic             advance;
    logic [2:0]       tx_sym;

    assign SymReady  = !fifo_full && !reset;
    assign State     = state_q;
    assign Phase     = phase_q;
    assign Underflow = undf_q;
    assign SymErr    = err_q;

    cphy_sym_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk_i    (TxSymbolClkHS),
        .rst_i    (reset),
        .push_i   (SymValid && SymReady),
        .wr_dat_i (SymIn),
        .pop_i    (pop),
        .rd_dat_o (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty)
    );

    always_comb begin
        phase_d = phase_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        undf_d  = 1'b0;
        err_d   = 1'b0;
        pop     = 1'b0;
        advance = 1'b0;
        tx_sym  = SYM_CCW_SAME;

        // Dropping the enable freezes the lane on this edge and discards sequence progress.
        if (!EncoderEn) begin
            phase_d = PH_IDLE;
            cnt_d   = '0;
        end else begin
            case (phase_q)
                PH_IDLE: begin
                    phase_d = PH_PREAMBLE;
                    cnt_d   = '0;
                end
                PH_PREAMBLE: begin
                    advance = 1'b1;
                    tx_sym  = SYM_PREAMBLE;
                    if (cnt_q == PRE_LAST) begin
                        phase_d = PH_SYNC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PH_SYNC: begin
                    advance = 1'b1;
                    tx_sym  = SYNC_SEQ[cnt_q[2:0]];
                    if (cnt_q == SYN_LAST) begin
                        phase_d = PH_DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PH_DATA: begin
                    advance = 1'b1;
                    if (!fifo_empty) begin
                        pop = 1'b1;
                        if (sym_legal(fifo_head)) tx_sym = fifo_head;
                        else                      err_d  = 1'b1;
                    end else begin
                        undf_d = 1'b1;
                    end
                end
                default: phase_d = PH_IDLE;
            endcase
        end

        if (advance) state_d = next_state(state_q, tx_sym);
    end

    always_ff @(posedge TxSymbolClkHS or posedge reset) begin
        if (reset) begin
            phase_q <= PH_IDLE;
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            undf_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            undf_q  <= undf_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cphy_symbol_encoder.sv
// Directed and randomized bench for the C-PHY lane encoder against a queue-based model.
module tb_cphy_symbol_encoder;

    localparam int DEPTH = 4;
    localparam int PLEN  = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       vld;
    logic [2:0] sym_in;
    logic       rdy;
    logic [2:0] state_o;
    logic [1:0] phase_o;
    logic       und;
    logic       err;

    int checks   = 0;
    int failures = 0;

    logic [2:0] m_state;
    int         m_phase;
    bit         m_act;
    bit         m_und;
    bit         m_err;
    bit         m_pushed;
    logic [2:0] m_q[$];
    int         m_pro[$];

    cphy_symbol_encoder #(
        .FIFO_DEPTH   (DEPTH),
        .PREAMBLE_LEN (PLEN),
        .RESET_STATE  (3'b011)
    ) dut (
        .TxSymbolClkHS (clk),
        .reset         (reset),
        .EncoderEn     (en),
        .SymIn         (sym_in),
        .SymValid      (vld),
        .SymReady      (rdy),
        .State         (state_o),
        .Phase         (phase_o),
        .Underflow     (und),
        .SymErr        (err)
    );

    always #5 clk = ~clk;

    // Wire-state transitions as rotations and complements on the 3-bit value.
    function automatic logic [2:0] ref_next(input logic [2:0] ps, input int s);
        int p;
        int rl;
        int rr;
        p  = int'(ps);
        rl = ((p << 1) | (p >> 2)) & 7;
        rr = ((p >> 1) | (p << 2)) & 7;
        case (s)
            1:       return 3'(7 - rl);
            2:       return 3'(rr);
            3:       return 3'(7 - rr);
            4:       return 3'(7 - p);
            default: return 3'(rl);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state  = 3'b011;
        m_phase  = 0;
        m_act    = 0;
        m_und    = 0;
        m_err    = 0;
        m_pushed = 0;
        m_q.delete();
        m_pro.delete();
    endtask

    task automatic model_edge(input bit e, input bit v, input logic [2:0] s);
        bit push_ok;
        int x;
        push_ok  = v && (m_q.size() < DEPTH);
        m_und    = 0;
        m_err    = 0;
        m_pushed = push_ok;
        if (!e) begin
            m_act   = 0;
            m_phase = 0;
            m_pro.delete();
        end else if (!m_act) begin
            m_act   = 1;
            m_phase = 1;
            m_pro.delete();
            for (int i = 0; i < PLEN; i++) m_pro.push_back(3);
            m_pro.push_back(3);
            for (int i = 0; i < 5; i++) m_pro.push_back(4);
            m_pro.push_back(3);
        end else if (m_pro.size() > 0) begin
            x       = m_pro.pop_front();
            m_state = ref_next(m_state, x);
            m_phase = (m_pro.size() > 7) ? 1 : (m_pro.size() > 0) ? 2 : 3;
        end else begin
            if (m_q.size() > 0) begin
                x = int'(m_q.pop_front());
                if (x > 4) begin
                    m_err = 1;
                    x     = 0;
                end
            end else begin
                m_und = 1;
                x     = 0;
            end
            m_state = ref_next(m_state, x);
        end
        if (push_ok) m_q.push_back(s);
    endtask

    task automatic compare_all(input string where);
        bit exp_rdy;
        exp_rdy = !reset && (m_q.size() < DEPTH);
        chk({where, ".state"},     8'(state_o), 8'(m_state));
        chk({where, ".phase"},     8'(phase_o), 8'(m_phase));
        chk({where, ".underflow"}, 8'(und),     8'(m_und));
        chk({where, ".symerr"},    8'(err),     8'(m_err));
        chk({where, ".ready"},     8'(rdy),     8'(exp_rdy));
    endtask

    task automatic step(input bit e, input bit v, input logic [2:0] s, input string where);
        en     = e;
        vld    = v;
        sym_in = s;
        @(posedge clk);
        model_edge(e, v, s);
        #1;
        compare_all(where);
    endtask

    task automatic do_reset(input string where);
        en     = 1'b0;
        vld    = 1'b0;
        reset  = 1'b1;
        #1;
        model_reset();
        compare_all({where, ".async"});
        @(posedge clk);
        #1;
        compare_all({where, ".held"});
        reset = 1'b0;
        #1;
        compare_all({where, ".released"});
    endtask

    initial begin
        logic [2:0] exp_pro [14];
        logic [2:0] single_sym [6];
        logic [2:0] single_exp [6];
        logic [2:0] saved;
        logic [2:0] rs;

        exp_pro    = '{3'b010, 3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010,
                       3'b110, 3'b001, 3'b110, 3'b001, 3'b110, 3'b001, 3'b011};
        single_sym = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
        single_exp = '{3'b110, 3'b001, 3'b101, 3'b010, 3'b100, 3'b110};

        reset  = 1'b1;
        en     = 1'b0;
        vld    = 1'b0;
        sym_in = 3'b000;
        model_reset();
        #2;
        compare_all("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("ready_after_reset", 8'(rdy), 8'd1);

        // Enable with no data: preamble, sync, then filler symbols.
        step(1, 0, 0, "enable");
        chk("enable_phase", 8'(phase_o), 8'd1);
        chk("enable_no_transition", 8'(state_o), 8'h3);
        for (int i = 0; i < 14; i++) begin
            step(1, 0, 0, "prologue");
            chk("prologue_state", 8'(state_o), 8'(exp_pro[i]));
        end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, "underflow");
            chk("underflow_pulse", 8'(und), 8'd1);
            chk("underflow_phase", 8'(phase_o), 8'd3);
        end

        // Single symbol loaded while idle, popped on the first DATA edge from state 011.
        for (int i = 0; i < 6; i++) begin
            do_reset("single_rst");
            step(0, 1, single_sym[i], "single_load");
            step(1, 0, 0, "single_en");
            for (int j = 0; j < 14; j++) step(1, 0, 0, "single_pro");
            step(1, 0, 0, "single_pop");
            chk("single_state", 8'(state_o), 8'(single_exp[i]));
            chk("single_symerr", 8'(err), 8'(i == 5));
            step(1, 0, 0, "single_after");
            chk("single_symerr_clear", 8'(err), 8'd0);
        end

        // Five back-to-back pushes into a four-entry FIFO while disabled.
        do_reset("fill_rst");
        for (int i = 0; i < 5; i++) begin
            chk("fill_ready_before", 8'(rdy), 8'(i < 4));
            step(0, 1, 3'(i), "fill");
        end
        chk("fill_ready_full", 8'(rdy), 8'd0);
        for (int i = 0; i < 15; i++) step(1, 1, 3'd4, "fill_pro");
        for (int i = 0; i < 4 && !m_pushed; i++) step(1, 1, 3'd4, "fill_retry");
        chk("fill_fifth_accepted", 8'(m_pushed), 8'd1);
        for (int i = 0; i < 7; i++) step(1, 0, 0, "fill_drain");
        chk("fill_drained_underflow", 8'(und), 8'd1);

        // Abort in the middle of SYNC, then restart the full preamble.
        do_reset("abort_rst");
        step(1, 0, 0, "abort_en");
        for (int i = 0; i < PLEN + 3; i++) step(1, 0, 0, "abort_run");
        chk("abort_in_sync", 8'(phase_o), 8'd2);
        saved = m_state;
        step(0, 0, 0, "abort_drop");
        chk("abort_phase", 8'(phase_o), 8'd0);
        chk("abort_frozen", 8'(state_o), 8'(saved));
        step(0, 0, 0, "abort_idle");
        chk("abort_still_frozen", 8'(state_o), 8'(saved));
        step(1, 0, 0, "abort_reen");
        chk("abort_reen_phase", 8'(phase_o), 8'd1);
        chk("abort_reen_state", 8'(state_o), 8'(saved));
        for (int i = 0; i < PLEN; i++) begin
            step(1, 0, 0, "abort_pre");
            chk("abort_pre_phase", 8'(phase_o), 8'(i == PLEN - 1 ? 2 : 1));
        end

        // Reset with two entries left in the FIFO during DATA.
        do_reset("midrst_prep");
        for (int i = 0; i < 3; i++) step(0, 1, 3'(i), "midrst_load");
        step(1, 0, 0, "midrst_en");
        for (int i = 0; i < 15; i++) step(1, 0, 0, "midrst_run");
        chk("midrst_entries", 8'(m_q.size()), 8'd2);
        do_reset("midrst");
        chk("midrst_state", 8'(state_o), 8'h3);
        step(1, 0, 0, "midrst_en2");
        chk("midrst_phase", 8'(phase_o), 8'd1);
        step(1, 0, 0, "midrst_first");
        chk("midrst_preamble_state", 8'(state_o), 8'h2);
        for (int i = 0; i < 13; i++) step(1, 0, 0, "midrst_pro");
        step(1, 0, 0, "midrst_data");
        chk("midrst_fifo_empty", 8'(und), 8'd1);

        // Randomized traffic with occasional resets and enable drops.
        do_reset("rand_rst");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset("rand_midrst");
            end else begin
                rs = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7))
                                                 : 3'($urandom_range(0, 4));
                step(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)), rs, "rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
